pixel_writer: RTL and testbench
===============================

// Module: pixel_writer
//
// PURPOSE
// - Consumes the (x, y, write-enable) pixel stream produced by the graphics rasterisers and commits each pixel
//   into the packed 4bpp framebuffer SPRAM.
// - Framebuffer word: 16 bits = 4 pixels; nibble n (n = pixel index mod 4) occupies bits [4n+3:4n].
// - Input side has no backpressure, so pixels are queued in a FIFO. Words are read-modify-written, and
//   successive pixels in the same word are coalesced into one write.
//
// PARAMETERS
// H_RES       640  pixels per line; pixel index = y*H_RES + x
// V_RES       400  lines; H_RES*V_RES/4 words must fit in 16-bit address
// FIFO_DEPTH  16   input pixel FIFO entries, power of two
//
// PORTS
// clock_in              in   1   system clock
// reset_in              in   1   synchronous reset, active high
// horizontal_in         in   10  pixel x from rasteriser
// vertical_in           in   9   pixel y from rasteriser
// write_enable_in       in   1   rasteriser asserts while coordinates are valid
// colour_in             in   4   colour index for the pixel, sampled with coordinates
// flush_in              in   1   pulse: write back cached word once FIFO drains
// mem_address_out       out  16  framebuffer word address
// mem_read_enable_out   out  1   read strobe; data valid on mem_read_data_in next cycle
// mem_read_data_in      in   16  read data
// mem_write_enable_out  out  1   write strobe, one cycle per word
// mem_write_data_out    out  16  write data
// idle_out              out  1   FIFO empty, no dirty word, state IDLE
// overflow_out          out  1   sticky: a pixel was dropped because FIFO was full
//
// BEHAVIOUR
// - Reset: all outputs 0 except idle_out=1; FIFO emptied; cached word and dirty flag cleared; overflow cleared.
// - Reset mid-operation: dirty word discarded, no write issued; reset has priority over all other inputs.
// - Capture rule (rasteriser holds coordinates >1 cycle): push {x,y,colour} when write_enable_in=1 and
//   (write_enable_in was 0 last cycle, or (x,y) differs from last cycle's registered x,y).
// - Out-of-range pixels (x>=H_RES or y>=V_RES) are discarded at capture and never enter the FIFO.
// - FIFO full at capture: pixel dropped, overflow_out set until reset. Push and pop in the same cycle when full:
//   the pop frees the slot and the push is accepted.
// - Address: p = y*H_RES + x (18 bit, shift-add); word = p[17:2]; nibble = p[1:0].
// - FSM states and transitions:
//   - IDLE
//     - FIFO non-empty -> pop -> FETCH.
//     - flush_in ignored (nothing dirty).
//   - FETCH
//     - mem_read_enable_out=1, mem_address_out=word -> MERGE.
//   - MERGE
//     - Latch mem_read_data_in, replace the target nibble with colour, set dirty -> HOLD.
//   - HOLD
//     - FIFO non-empty, head in same word: pop, merge nibble in 1 cycle, stay in HOLD.
//     - FIFO non-empty, different word: -> WRITEBACK (head not popped).
//     - FIFO empty and (flush_in=1, or flush pending, or write_enable_in=0): -> WRITEBACK.
//   - WRITEBACK
//     - mem_write_enable_out=1 with cached word/address, clear dirty.
//     - FIFO non-empty: pop -> FETCH. Otherwise -> IDLE.
// - flush_in arriving while busy is latched as pending and honoured on the next HOLD with FIFO empty.
// - Same-word hit costs 1 cycle; word miss costs 3 cycles (WRITEBACK, FETCH, MERGE).
// - Memory strobes are never asserted together; at most one strobe per cycle.
// - Latency: a first pixel captured at cycle N (idle) is read at N+2 and, if isolated, written at N+5.
// - Repeated same-coordinate pixels are not pushed (capture rule). Later colour overwrites an earlier colour
//   at the same coordinate.
//
// TESTING
// - Single pixel (x=5,y=0,colour=0xA) with mem word 0x1234 at addr 1 -> one read addr 1, one write 0x12A4, idle_out=1.
// - Horizontal run x=0..7,y=2, colour=3, write_enable held 16 cycles (coords change every 2) -> 2 reads/2 writes,
//   addr 320 and 321, both 0x3333.
// - Vertical run x=0,y=0..39, one pixel/2 cycles, FIFO_DEPTH=16 -> 40 RMW at addr 0,160,...,6240; overflow_out stays 0.
// - Vertical run of 200 px at 1 px/cycle -> overflow_out=1 and stays 1; written pixels are a subset in order.
// - Pixels x=640,y=0 and x=0,y=400 -> no memory activity, idle_out stays 1.
// - Reset asserted in HOLD with dirty word -> no mem_write_enable_out pulse; all outputs at reset values next cycle.

Source files
------------

// File: rtl/pixel_writer.sv
// pixel_writer: queues rasteriser pixels and read-modify-writes them into a
// packed 4bpp framebuffer, coalescing same-word pixels into a single write.
//
// Ports:
//   clock_in, reset_in (sync, active high)
//   horizontal_in/vertical_in/write_enable_in/colour_in : rasteriser pixel stream
//   flush_in             : write back the cached word once the FIFO drains
//   mem_address_out      : framebuffer word address (valid with a strobe, else 0)
//   mem_read_enable_out  : read strobe, data on mem_read_data_in next cycle
//   mem_read_data_in     : read data
//   mem_write_enable_out : write strobe, one cycle per word
//   mem_write_data_out   : write data (valid with the write strobe, else 0)
//   idle_out             : FIFO empty, nothing dirty, FSM idle
//   overflow_out         : sticky, a pixel was dropped on a full FIFO
module pixel_writer #(
  parameter int H_RES      = 640,
  parameter int V_RES      = 400,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clock_in,
  input  logic        reset_in,
  input  logic [9:0]  horizontal_in,
  input  logic [8:0]  vertical_in,
  input  logic        write_enable_in,
  input  logic [3:0]  colour_in,
  input  logic        flush_in,
  output logic [15:0] mem_address_out,
  output logic        mem_read_enable_out,
  input  logic [15:0] mem_read_data_in,
  output logic        mem_write_enable_out,
  output logic [15:0] mem_write_data_out,
  output logic        idle_out,
  output logic        overflow_out
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_MERGE = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_WB    = 3'd4;

  function automatic logic [15:0] put_nib(
    input logic [15:0] w,
    input logic [1:0]  n,
    input logic [3:0]  c
  );
    logic [15:0] r;
    r = w;
    r[{n, 2'b00} +: 4] = c;
    return r;
  endfunction

  // capture
  logic        prev_we_q, prev_we_d;
  logic [9:0]  prev_x_q, prev_x_d;
  logic [8:0]  prev_y_q, prev_y_d;
  logic        in_range;
  logic        capture;
  logic [17:0] pix_idx;
  logic [21:0] push_entry;

  // fifo entry: {word[15:0], nibble[1:0], colour[3:0]}
  logic [21:0] fifo_mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        empty, full, push, pop;
  logic [21:0] head;
  logic [15:0] head_word;

  // fsm / cache
  logic [2:0]  state_q, state_d;
  logic [15:0] word_q, word_d;
  logic [1:0]  nib_q, nib_d;
  logic [3:0]  col_q, col_d;
  logic [15:0] cache_q, cache_d;
  logic        dirty_q, dirty_d;
  logic        flush_pend_q, flush_pend_d;
  logic        overflow_q, overflow_d;

  assign in_range = (32'(horizontal_in) < H_RES) &&
                    (32'(vertical_in) < V_RES);

  // constant multiply: the tool reduces it to a shift-add
  assign pix_idx = 18'(vertical_in) * 18'(H_RES) +
                   18'(horizontal_in);

  assign push_entry = {pix_idx[17:2], pix_idx[1:0], colour_in};

  // a held coordinate is pushed once; a new one while held is pushed too
  assign capture = write_enable_in && in_range &&
                   (!prev_we_q ||
                    horizontal_in != prev_x_q ||
                    vertical_in != prev_y_q);

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // a pop in the same cycle frees a slot for a push when full
  assign push = capture && (!full || pop);

  assign head      = fifo_mem_q[rd_ptr_q[AW-1:0]];
  assign head_word = head[21:6];

  always_comb begin
    prev_we_d    = write_enable_in;
    prev_x_d     = horizontal_in;
    prev_y_d     = vertical_in;
    state_d      = state_q;
    word_d       = word_q;
    nib_d        = nib_q;
    col_d        = col_q;
    cache_d      = cache_q;
    dirty_d      = dirty_q;
    flush_pend_d = flush_pend_q;
    pop          = 1'b0;

    if (flush_in && state_q != S_IDLE) begin
      flush_pend_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          word_d  = head_word;
          nib_d   = head[5:4];
          col_d   = head[3:0];
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        state_d = S_MERGE;
      end
      S_MERGE: begin
        cache_d = put_nib(mem_read_data_in, nib_q, col_q);
        dirty_d = 1'b1;
        // a queued miss skips HOLD so a miss costs WB+FETCH+MERGE
        if (!empty && head_word != word_q) begin
          state_d = S_WB;
        end else begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (!empty) begin
          if (head_word == word_q) begin
            pop     = 1'b1;
            cache_d = put_nib(cache_q, head[5:4], head[3:0]);
          end else begin
            state_d = S_WB;
          end
        end else if (flush_in || flush_pend_q ||
                     !write_enable_in) begin
          flush_pend_d = 1'b0;
          state_d      = S_WB;
        end
      end
      S_WB: begin
        dirty_d = 1'b0;
        if (!empty) begin
          pop     = 1'b1;
          word_d  = head_word;
          nib_d   = head[5:4];
          col_d   = head[3:0];
          state_d = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    overflow_d = overflow_q || (capture && !push);
  end

  always_ff @(posedge clock_in) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q[AW-1:0]] <= push_entry;
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      prev_we_q    <= 1'b0;
      prev_x_q     <= '0;
      prev_y_q     <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      state_q      <= S_IDLE;
      word_q       <= '0;
      nib_q        <= '0;
      col_q        <= '0;
      cache_q      <= '0;
      dirty_q      <= 1'b0;
      flush_pend_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      prev_we_q    <= prev_we_d;
      prev_x_q     <= prev_x_d;
      prev_y_q     <= prev_y_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      state_q      <= state_d;
      word_q       <= word_d;
      nib_q        <= nib_d;
      col_q        <= col_d;
      cache_q      <= cache_d;
      dirty_q      <= dirty_d;
      flush_pend_q <= flush_pend_d;
      overflow_q   <= overflow_d;
    end
  end

  assign mem_read_enable_out  = (state_q == S_FETCH);
  assign mem_write_enable_out = (state_q == S_WB);
  assign mem_address_out =
    (mem_read_enable_out || mem_write_enable_out) ? word_q : '0;
  assign mem_write_data_out =
    mem_write_enable_out ? cache_q : '0;
  assign idle_out = empty && !dirty_q && (state_q == S_IDLE);
  assign overflow_out = overflow_q;

endmodule

// File: tb/tb_pixel_writer.sv
// tb_pixel_writer: directed bench for pixel_writer with a behavioural
// framebuffer SPRAM that logs every read and write strobe.
module tb_pixel_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  x;
  logic [8:0]  y;
  logic        we;
  logic [3:0]  col;
  logic        flush;
  logic [15:0] addr;
  logic        rd_en;
  logic [15:0] rd_data;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        idle;
  logic        ovf;

  always #5 clk = ~clk;

  pixel_writer dut (
    .clock_in             (clk),
    .reset_in             (rst),
    .horizontal_in        (x),
    .vertical_in          (y),
    .write_enable_in      (we),
    .colour_in            (col),
    .flush_in             (flush),
    .mem_address_out      (addr),
    .mem_read_enable_out  (rd_en),
    .mem_read_data_in     (rd_data),
    .mem_write_enable_out (wr_en),
    .mem_write_data_out   (wr_data),
    .idle_out             (idle),
    .overflow_out         (ovf)
  );

  // framebuffer model: word 1 preloaded with 0x1234, everything else 0
  bit [15:0] mem   [65536];
  bit        valid [65536];
  int        cyc = 0;
  int        rd_addr_q [$];
  int        rd_cyc_q  [$];
  int        wr_addr_q [$];
  int        wr_data_q [$];
  int        wr_cyc_q  [$];
  bit        both_seen = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_en) begin
      if (valid[addr]) rd_data <= mem[addr];
      else rd_data <= (addr == 16'd1) ? 16'h1234 : 16'h0000;
      rd_addr_q.push_back(int'(addr));
      rd_cyc_q.push_back(cyc);
    end
    if (wr_en) begin
      mem[addr]   <= wr_data;
      valid[addr] <= 1'b1;
      wr_addr_q.push_back(int'(addr));
      wr_data_q.push_back(int'(wr_data));
      wr_cyc_q.push_back(cyc);
    end
    if (rd_en && wr_en) both_seen <= 1'b1;
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (!idle && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check(tag, idle, 1);
  endtask

  int rb, wb, c0, bad, busy, last;

  initial begin
    rst = 1'b1; x = '0; y = '0; we = 1'b0;
    col = '0; flush = 1'b0; rd_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_addr", addr, 0);
    check("rst_rd", rd_en, 0);
    check("rst_wr", wr_en, 0);
    check("rst_wdata", wr_data, 0);
    check("rst_idle", idle, 1);
    check("rst_ovf", ovf, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    step(2);

    // single pixel x=5 y=0 -> word 1 nibble 1
    rb = rd_addr_q.size(); wb = wr_addr_q.size();
    x = 10'd5; y = 9'd0; col = 4'hA; we = 1'b1;
    c0 = cyc;
    step(1);
    we = 1'b0;
    wait_idle("single_idle");
    check("single_nrd", rd_addr_q.size() - rb, 1);
    check("single_nwr", wr_addr_q.size() - wb, 1);
    check("single_rd_addr", rd_addr_q[rb], 1);
    check("single_rd_lat", rd_cyc_q[rb] - c0, 2);
    check("single_wr_addr", wr_addr_q[wb], 1);
    check("single_wr_data", wr_data_q[wb], 32'h12A4);
    check("single_wr_lat", wr_cyc_q[wb] - c0, 5);

    // horizontal run x=0..7 y=2, coords change every 2 cycles
    step(2);
    rb = rd_addr_q.size(); wb = wr_addr_q.size();
    for (int i = 0; i < 8; i++) begin
      x = 10'(i); y = 9'd2; col = 4'h3; we = 1'b1;
      step(2);
    end
    we = 1'b0;
    wait_idle("hrun_idle");
    check("hrun_nrd", rd_addr_q.size() - rb, 2);
    check("hrun_nwr", wr_addr_q.size() - wb, 2);
    check("hrun_addr0", wr_addr_q[wb], 320);
    check("hrun_addr1", wr_addr_q[wb+1], 321);
    check("hrun_data0", wr_data_q[wb], 32'h3333);
    check("hrun_data1", wr_data_q[wb+1], 32'h3333);

    // held pixel parks in HOLD until flush: p=6500 -> word 1625
    step(2);
    wb = wr_addr_q.size();
    x = 10'd100; y = 9'd10; col = 4'h7; we = 1'b1;
    step(10);
    check("flush_nowr", wr_addr_q.size() - wb, 0);
    check("flush_busy", idle, 0);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    wait_idle("flush_idle");
    check("flush_nwr", wr_addr_q.size() - wb, 1);
    check("flush_addr", wr_addr_q[wb], 1625);
    check("flush_data", wr_data_q[wb], 32'h0007);
    we = 1'b0;
    step(4);
    check("flush_norepush", wr_addr_q.size() - wb, 1);

    // vertical run x=0 y=0..39, one pixel per 2 cycles
    rb = rd_addr_q.size(); wb = wr_addr_q.size();
    for (int i = 0; i < 40; i++) begin
      x = 10'd0; y = 9'(i); col = 4'h5; we = 1'b1;
      step(2);
    end
    we = 1'b0;
    wait_idle("vrun_idle");
    check("vrun_nrd", rd_addr_q.size() - rb, 40);
    check("vrun_nwr", wr_addr_q.size() - wb, 40);
    check("vrun_ovf", ovf, 0);
    bad = 0;
    if (wr_addr_q.size() - wb == 40) begin
      for (int i = 0; i < 40; i++) begin
        if (wr_addr_q[wb+i] != i * 160) bad++;
        // word 320 already holds 0x3333 from the horizontal run
        if (wr_data_q[wb+i] != ((i == 2) ? 32'h3335 : 32'h0005))
          bad++;
      end
    end
    check("vrun_content", bad, 0);

    // out-of-range pixels never reach memory
    step(2);
    rb = rd_addr_q.size(); wb = wr_addr_q.size();
    busy = 0;
    x = 10'd640; y = 9'd0; col = 4'h1; we = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); if (!idle) busy++;
    end
    step(0);
    x = 10'd0; y = 9'd400;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); if (!idle) busy++;
    end
    we = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); if (!idle) busy++;
    end
    check("oor_busy", busy, 0);
    check("oor_nrd", rd_addr_q.size() - rb, 0);
    check("oor_nwr", wr_addr_q.size() - wb, 0);

    // 200 pixels at 1/cycle overflow the FIFO
    @(posedge clk); #1;
    wb = wr_addr_q.size();
    for (int i = 0; i < 200; i++) begin
      x = 10'd1; y = 9'(i); col = 4'h9; we = 1'b1;
      step(1);
    end
    we = 1'b0;
    wait_idle("ovf_idle");
    check("ovf_set", ovf, 1);
    check("ovf_subset", (wr_addr_q.size() - wb) < 200, 1);
    check("ovf_some", (wr_addr_q.size() - wb) > 0, 1);
    bad = 0;
    last = -1;
    for (int i = wb; i < wr_addr_q.size(); i++) begin
      if (wr_addr_q[i] <= last) bad++;
      if (wr_addr_q[i] % 160 != 0) bad++;
      last = wr_addr_q[i];
    end
    check("ovf_order", bad, 0);
    step(20);
    check("ovf_sticky", ovf, 1);

    // reset while parked in HOLD with a dirty word
    wb = wr_addr_q.size();
    x = 10'd8; y = 9'd0; col = 4'hF; we = 1'b1;
    step(8);
    check("rhold_busy", idle, 0);
    rst = 1'b1; we = 1'b0;
    @(negedge clk);
    check("rhold_nowr_now", wr_en, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rhold_addr", addr, 0);
    check("rhold_rd", rd_en, 0);
    check("rhold_wr", wr_en, 0);
    check("rhold_idle", idle, 1);
    check("rhold_ovf", ovf, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    step(10);
    check("rhold_nwr", wr_addr_q.size() - wb, 0);
    check("rhold_idle_after", idle, 1);

    check("strobe_excl", both_seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
